// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: inter-stage bus widths, ALU opcode bit positions and bus layouts.
package pipeline_defs;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ALU_OP_W      = 12;
  localparam int unsigned ID_EXE_BUS_W  = 180;
  localparam int unsigned EXE_MEM_BUS_W = 103;
  localparam int unsigned EXE_FWD_BUS_W = 39;

  // One-hot alu_op bit positions
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_src1;
    logic [DATA_W-1:0]   alu_src2;
    logic                gr_we;
    logic                mem_we;
    logic                res_from_mem;
    logic [4:0]          dest;
    logic [DATA_W-1:0]   rkd_value;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   inst;
  } id_exe_bus_t;

  typedef struct packed {
    logic              gr_we;
    logic              res_from_mem;
    logic [4:0]        dest;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] alu_result;
  } exe_mem_bus_t;

  typedef struct packed {
    logic              fwd_we;
    logic              fwd_is_load;
    logic [4:0]        fwd_dest;
    logic [DATA_W-1:0] fwd_data;
  } exe_fwd_bus_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by a one-hot operation vector; sub/slt/sltu share one adder.
module alu
  import pipeline_defs::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_src1,
  input  logic [DATA_W-1:0]   alu_src2,
  output logic [DATA_W-1:0]   alu_result
);

  logic              use_sub;
  logic [DATA_W-1:0] adder_b;
  logic [DATA_W-1:0] adder_res;
  logic              adder_cout;
  logic              slt_res;
  logic              sltu_res;
  logic [DATA_W-1:0] sll_res;
  logic [DATA_W-1:0] srl_res;
  logic [DATA_W-1:0] sra_res;

  assign use_sub = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
  assign adder_b = use_sub ? ~alu_src2 : alu_src2;
  assign {adder_cout, adder_res} = {1'b0, alu_src1} + {1'b0, adder_b} + {{DATA_W{1'b0}}, use_sub};

  // Signed less-than: differing signs decide directly, otherwise the difference sign does
  assign slt_res  = (alu_src1[DATA_W-1] & ~alu_src2[DATA_W-1])
                  | (~(alu_src1[DATA_W-1] ^ alu_src2[DATA_W-1]) & adder_res[DATA_W-1]);
  assign sltu_res = ~adder_cout;

  assign sll_res = alu_src1 << alu_src2[4:0];
  assign srl_res = alu_src1 >> alu_src2[4:0];
  assign sra_res = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

  always_comb begin
    alu_result = '0;
    if (alu_op[ALU_ADD] | use_sub & ~alu_op[ALU_SLT] & ~alu_op[ALU_SLTU]) begin
      alu_result = alu_result | adder_res;
    end
    if (alu_op[ALU_SLT])  alu_result = alu_result | {{(DATA_W-1){1'b0}}, slt_res};
    if (alu_op[ALU_SLTU]) alu_result = alu_result | {{(DATA_W-1){1'b0}}, sltu_res};
    if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_SLL])  alu_result = alu_result | sll_res;
    if (alu_op[ALU_SRL])  alu_result = alu_result | srl_res;
    if (alu_op[ALU_SRA])  alu_result = alu_result | sra_res;
    if (alu_op[ALU_LUI])  alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches ID->EXE under valid/allowin, runs the ALU, issues data-SRAM requests
// in the transfer cycle and drives the EXE->MEM and ID forwarding buses.
module exe_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALU_OP_W = 12
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  output logic                                   exe_allowin,
  input  logic                                   id_exe_valid,
  input  logic [pipeline_defs::ID_EXE_BUS_W-1:0] id_exe_bus,
  output logic                                   exe_mem_valid,
  input  logic                                   mem_allowin,
  output logic [pipeline_defs::EXE_MEM_BUS_W-1:0] exe_mem_bus,
  output logic [pipeline_defs::EXE_FWD_BUS_W-1:0] exe_fwd_bus,
  output logic                                   data_sram_en,
  output logic [3:0]                             data_sram_we,
  output logic [DATA_W-1:0]                      data_sram_addr,
  output logic [DATA_W-1:0]                      data_sram_wdata
);

  import pipeline_defs::*;

  logic              exe_valid_q;
  logic              exe_valid;
  logic              exe_ready_go;
  logic              fire;
  id_exe_bus_t       bus_q;
  logic [ALU_OP_W-1:0] alu_op;
  logic [DATA_W-1:0] alu_result;
  exe_mem_bus_t      mem_bus;
  exe_fwd_bus_t      fwd_bus;

  assign exe_ready_go = 1'b1;
  // Masking with resetn keeps every request and forward inactive during the reset cycle
  assign exe_valid     = exe_valid_q & resetn;
  assign exe_allowin   = ~exe_valid | (exe_ready_go & mem_allowin);
  assign exe_mem_valid = exe_valid & exe_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
    end else if (exe_allowin) begin
      exe_valid_q <= id_exe_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (id_exe_valid && exe_allowin) begin
      bus_q <= id_exe_bus_t'(id_exe_bus);
    end
  end

  assign alu_op = bus_q.alu_op;

  alu u_alu (
    .alu_op     (alu_op),
    .alu_src1   (bus_q.alu_src1),
    .alu_src2   (bus_q.alu_src2),
    .alu_result (alu_result)
  );

  // Requests only in the transfer cycle so a stall never repeats a store or loses read data
  assign fire            = exe_valid & mem_allowin;
  assign data_sram_en    = fire & (bus_q.mem_we | bus_q.res_from_mem);
  assign data_sram_we    = {4{fire & bus_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bus_q.rkd_value;

  always_comb begin
    mem_bus.gr_we        = bus_q.gr_we;
    mem_bus.res_from_mem = bus_q.res_from_mem;
    mem_bus.dest         = bus_q.dest;
    mem_bus.pc           = bus_q.pc;
    mem_bus.inst         = bus_q.inst;
    mem_bus.alu_result   = alu_result;
  end

  always_comb begin
    fwd_bus.fwd_we      = exe_valid & bus_q.gr_we & (bus_q.dest != 5'd0);
    fwd_bus.fwd_is_load = exe_valid & bus_q.res_from_mem;
    fwd_bus.fwd_dest    = bus_q.dest;
    fwd_bus.fwd_data    = alu_result;
  end

  assign exe_mem_bus = mem_bus;
  assign exe_fwd_bus = fwd_bus;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vector table, hand sequences for stall/reset, and random traffic
// checked every cycle against a transaction-level model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         exe_allowin;
  logic         id_exe_valid;
  logic [179:0] id_exe_bus;
  logic         exe_mem_valid;
  logic         mem_allowin;
  logic [102:0] exe_mem_bus;
  logic [38:0]  exe_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        gr_we;
    logic        mem_we;
    logic        rfm;
    logic [4:0]  dest;
    logic [31:0] rkd;
    logic [31:0] pc;
    logic [31:0] inst;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] exp_res;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic        exp_fwd_we;
    logic        exp_ld;
  } vec_t;

  instr_t cur;
  instr_t m_ins;
  logic   m_valid;
  int     tests = 0;
  int     fails = 0;

  function automatic logic [179:0] pack_instr(instr_t i);
    return {i.op, i.s1, i.s2, i.gr_we, i.mem_we, i.rfm, i.dest, i.rkd, i.pc, i.inst};
  endfunction

  assign id_exe_bus = pack_instr(cur);

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .exe_allowin     (exe_allowin),
    .id_exe_valid    (id_exe_valid),
    .id_exe_bus      (id_exe_bus),
    .exe_mem_valid   (exe_mem_valid),
    .mem_allowin     (mem_allowin),
    .exe_mem_bus     (exe_mem_bus),
    .exe_fwd_bus     (exe_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  function automatic logic [11:0] onehot(int k);
    logic [11:0] v;
    v = 12'd1;
    return v << k;
  endfunction

  function automatic logic [31:0] ref_alu(logic [11:0] op, logic [31:0] a, logic [31:0] b);
    int idx;
    idx = -1;
    for (int k = 0; k < 12; k++) if (op[k]) idx = k;
    case (idx)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return $unsigned($signed(a) >>> b[4:0]);
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mk(int k, logic [31:0] s1, logic [31:0] s2, logic gr, logic mw,
                                logic rfm, logic [4:0] dest, logic [31:0] rkd, logic [31:0] pc);
    instr_t i;
    i.op = onehot(k); i.s1 = s1; i.s2 = s2; i.gr_we = gr; i.mem_we = mw; i.rfm = rfm;
    i.dest = dest; i.rkd = rkd; i.pc = pc; i.inst = pc ^ 32'h0280_0000;
    return i;
  endfunction

  task automatic chk(string name, logic [179:0] act, logic [179:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the model's resident instruction and current inputs
  task automatic model_check();
    logic        v;
    logic        fire;
    logic [31:0] r;
    v    = m_valid & resetn;
    fire = v & mem_allowin;
    r    = ref_alu(m_ins.op, m_ins.s1, m_ins.s2);
    chk("m_allowin", exe_allowin, !v | mem_allowin);
    chk("m_mem_valid", exe_mem_valid, v);
    chk("m_en", data_sram_en, fire & (m_ins.mem_we | m_ins.rfm));
    chk("m_we", data_sram_we, {4{fire & m_ins.mem_we}});
    chk("m_fwd_we", exe_fwd_bus[38], v & m_ins.gr_we & (m_ins.dest != 5'd0));
    chk("m_fwd_is_load", exe_fwd_bus[37], v & m_ins.rfm);
    if (v) begin
      chk("m_mem_bus", exe_mem_bus,
          {m_ins.gr_we, m_ins.rfm, m_ins.dest, m_ins.pc, m_ins.inst, r});
      chk("m_fwd_dest_data", exe_fwd_bus[36:0], {m_ins.dest, r});
      if (fire & (m_ins.mem_we | m_ins.rfm)) begin
        chk("m_addr", data_sram_addr, r);
        chk("m_wdata", data_sram_wdata, m_ins.rkd);
      end
    end
  endtask

  task automatic model_update();
    if (!resetn) begin
      m_valid = 1'b0;
    end else if (!m_valid || mem_allowin) begin
      m_valid = id_exe_valid;
      if (id_exe_valid) m_ins = cur;
    end
  endtask

  // Inputs are changed at posedge+1; the model is checked at negedge and advanced at posedge
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t vecs[14];
  instr_t st_i;
  instr_t add_i;
  instr_t ld_i;
  int     stores;

  initial begin
    vecs[0]  = '{mk(0, 32'd5, 32'd7, 1, 0, 0, 5'd3, 32'd0, 32'h1c00_0000),
                 32'h0000_000c, 0, 4'h0, 1, 0};
    vecs[1]  = '{mk(0, 32'h1c00_0100, 32'd0, 0, 1, 0, 5'd4, 32'hdead_beef, 32'h1c00_0004),
                 32'h1c00_0100, 1, 4'hf, 0, 0};
    vecs[2]  = '{mk(0, 32'h1c00_00f0, 32'h10, 1, 0, 1, 5'd5, 32'd0, 32'h1c00_0008),
                 32'h1c00_0100, 1, 4'h0, 1, 1};
    vecs[3]  = '{mk(0, 32'd1, 32'd1, 1, 0, 0, 5'd0, 32'd0, 32'h1c00_000c),
                 32'd2, 0, 4'h0, 0, 0};
    vecs[4]  = '{mk(1, 32'd3, 32'd5, 1, 0, 0, 5'd6, 32'd0, 32'h1c00_0010),
                 32'hffff_fffe, 0, 4'h0, 1, 0};
    vecs[5]  = '{mk(2, 32'hffff_ffff, 32'd1, 1, 0, 0, 5'd7, 32'd0, 32'h1c00_0014),
                 32'd1, 0, 4'h0, 1, 0};
    vecs[6]  = '{mk(3, 32'hffff_ffff, 32'd1, 1, 0, 0, 5'd8, 32'd0, 32'h1c00_0018),
                 32'd0, 0, 4'h0, 1, 0};
    vecs[7]  = '{mk(5, 32'd0, 32'd0, 1, 0, 0, 5'd9, 32'd0, 32'h1c00_001c),
                 32'hffff_ffff, 0, 4'h0, 1, 0};
    vecs[8]  = '{mk(8, 32'd1, 32'd31, 1, 0, 0, 5'd10, 32'd0, 32'h1c00_0020),
                 32'h8000_0000, 0, 4'h0, 1, 0};
    vecs[9]  = '{mk(10, 32'h8000_0000, 32'd4, 1, 0, 0, 5'd11, 32'd0, 32'h1c00_0024),
                 32'hf800_0000, 0, 4'h0, 1, 0};
    vecs[10] = '{mk(9, 32'h8000_0000, 32'd4, 1, 0, 0, 5'd12, 32'd0, 32'h1c00_0028),
                 32'h0800_0000, 0, 4'h0, 1, 0};
    vecs[11] = '{mk(11, 32'h1234_5678, 32'habcd_e000, 1, 0, 0, 5'd13, 32'd0, 32'h1c00_002c),
                 32'habcd_e000, 0, 4'h0, 1, 0};
    vecs[12] = '{mk(4, 32'h0000_f0f0, 32'h0000_ff00, 1, 0, 0, 5'd14, 32'd0, 32'h1c00_0030),
                 32'h0000_f000, 0, 4'h0, 1, 0};
    vecs[13] = '{mk(7, 32'haaaa_0000, 32'hffff_0000, 1, 0, 0, 5'd15, 32'd0, 32'h1c00_0034),
                 32'h5555_0000, 0, 4'h0, 1, 0};

    // Reset
    m_valid = 1'b0; m_ins = '0; cur = '0;
    resetn = 1'b0; id_exe_valid = 1'b0; mem_allowin = 1'b0;
    #1;
    chk("rst_allowin", exe_allowin, 1'b1);
    chk("rst_mem_valid", exe_mem_valid, 1'b0);
    chk("rst_en", data_sram_en, 1'b0);
    chk("rst_we", data_sram_we, 4'h0);
    chk("rst_fwd", exe_fwd_bus[38:37], 2'b00);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("post_rst_allowin", exe_allowin, 1'b1);
    chk("post_rst_mem_valid", exe_mem_valid, 1'b0);
    chk("post_rst_en", data_sram_en, 1'b0);
    chk("post_rst_fwd", exe_fwd_bus[38:37], 2'b00);
    tick();

    // Directed vectors: issue one, then check it the following cycle
    foreach (vecs[i]) begin
      cur = vecs[i].ins; id_exe_valid = 1'b1; mem_allowin = 1'b1;
      tick();
      id_exe_valid = 1'b0;
      #1;
      chk("vec_mem_valid", exe_mem_valid, 1'b1);
      chk("vec_result", exe_mem_bus[31:0], vecs[i].exp_res);
      chk("vec_en", data_sram_en, vecs[i].exp_en);
      chk("vec_we", data_sram_we, vecs[i].exp_we);
      chk("vec_fwd_we", exe_fwd_bus[38], vecs[i].exp_fwd_we);
      chk("vec_fwd_ld", exe_fwd_bus[37], vecs[i].exp_ld);
      chk("vec_bus_flags", exe_mem_bus[102:96],
          {vecs[i].ins.gr_we, vecs[i].ins.rfm, vecs[i].ins.dest});
      if (vecs[i].exp_en) begin
        chk("vec_addr", data_sram_addr, vecs[i].exp_res);
        chk("vec_wdata", data_sram_wdata, vecs[i].ins.rkd);
      end
      tick();
    end

    // Backpressure with a resident store and a waiting ID instruction
    st_i  = mk(0, 32'h1c00_0100, 32'd0, 0, 1, 0, 5'd0, 32'hdead_beef, 32'h1c00_0100);
    add_i = mk(0, 32'd5, 32'd7, 1, 0, 0, 5'd3, 32'd0, 32'h1c00_0200);
    stores = 0;
    cur = st_i; id_exe_valid = 1'b1; mem_allowin = 1'b0;
    tick();
    cur = add_i;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_allowin", exe_allowin, 1'b0);
      chk("bp_en", data_sram_en, 1'b0);
      chk("bp_we", data_sram_we, 4'h0);
      chk("bp_bus", exe_mem_bus,
          {1'b0, 1'b0, 5'd0, 32'h1c00_0100, 32'h1c00_0100 ^ 32'h0280_0000, 32'h1c00_0100});
      if (data_sram_we != 4'h0) stores++;
      tick();
    end
    mem_allowin = 1'b1;
    #1;
    chk("bp_rel_en", data_sram_en, 1'b1);
    chk("bp_rel_we", data_sram_we, 4'hf);
    chk("bp_rel_addr", data_sram_addr, 32'h1c00_0100);
    chk("bp_rel_wdata", data_sram_wdata, 32'hdead_beef);
    if (data_sram_we != 4'h0) stores++;
    tick();
    id_exe_valid = 1'b0;
    #1;
    if (data_sram_we != 4'h0) stores++;
    chk("bp_one_store", stores, 1);
    chk("bp_next_pc", exe_mem_bus[95:64], 32'h1c00_0200);
    chk("bp_next_res", exe_mem_bus[31:0], 32'h0000_000c);
    chk("bp_next_valid", exe_mem_valid, 1'b1);
    tick();

    // Back-to-back adds, no bubbles
    for (int i = 0; i < 4; i++) begin
      cur = mk(0, 32'd100 * i, 32'd1, 1, 0, 0, 5'(i + 1), 32'd0, 32'h1c00_0300 + 32'(4 * i));
      id_exe_valid = 1'b1; mem_allowin = 1'b1;
      tick();
      #1;
      chk("b2b_valid", exe_mem_valid, 1'b1);
      chk("b2b_res", exe_mem_bus[31:0], 32'd100 * i + 32'd1);
      chk("b2b_allowin", exe_allowin, 1'b1);
    end
    id_exe_valid = 1'b0;
    tick();

    // Reset while a load is stalled
    ld_i = mk(0, 32'h1c00_00f0, 32'h10, 1, 0, 1, 5'd5, 32'd0, 32'h1c00_0400);
    cur = ld_i; id_exe_valid = 1'b1; mem_allowin = 1'b0;
    tick();
    id_exe_valid = 1'b0;
    tick();
    #1;
    chk("rs_stalled_ld", exe_fwd_bus[37], 1'b1);
    chk("rs_stalled_en", data_sram_en, 1'b0);
    resetn = 1'b0;
    #1;
    chk("rs_in_mem_valid", exe_mem_valid, 1'b0);
    chk("rs_in_en", data_sram_en, 1'b0);
    chk("rs_in_fwd_ld", exe_fwd_bus[37], 1'b0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rs_out_mem_valid", exe_mem_valid, 1'b0);
    chk("rs_out_allowin", exe_allowin, 1'b1);
    chk("rs_out_en", data_sram_en, 1'b0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [1:0] kind;
      resetn       = ($urandom_range(0, 59) != 0);
      id_exe_valid = $urandom_range(0, 3) != 0;
      mem_allowin  = $urandom_range(0, 3) != 0;
      kind = 2'($urandom_range(0, 2));
      cur = mk(int'($urandom_range(0, 11)), $urandom, $urandom, kind != 2'd1, kind == 2'd1,
               kind == 2'd2, 5'($urandom_range(0, 31)), $urandom, $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
